// File: rtl/stage_sequencer_if.sv
// Bus between the keyboard decoder / gameplay blocks and the stage sequencer.
// The master drives raw keys, lives and level_clear. The slave (the sequencer) drives stage and the gated keys.
interface stage_sequencer_if;
  logic       key_a;
  logic       key_d;
  logic       key_w;
  logic       key_s;
  logic       key_space;
  logic       key_enter;
  logic [3:0] lives;
  logic       level_clear;
  logic [3:0] stage;
  logic       mc_a;
  logic       mc_d;
  logic       mc_w;
  logic       mc_s;
  logic       mc_space;
  logic       freeze;
  logic       level_start;
  logic [2:0] fsm_state;

  modport master (
    output key_a, key_d, key_w, key_s, key_space, key_enter, lives, level_clear,
    input  stage, mc_a, mc_d, mc_w, mc_s, mc_space, freeze, level_start, fsm_state
  );

  modport slave (
    input  key_a, key_d, key_w, key_s, key_space, key_enter, lives, level_clear,
    output stage, mc_a, mc_d, mc_w, mc_s, mc_space, freeze, level_start, fsm_state
  );
endinterface

// File: rtl/stage_sequencer.sv
// Game-flow controller: title -> intro -> play -> clear -> ... -> win/over.
// Gates the raw movement keys so the character is frozen outside active play.
module stage_sequencer #(
  parameter int NUM_LEVELS   = 3,
  parameter int TRANS_CYCLES = 120,
  parameter int OVER_HOLD    = 200
) (
  input logic              clk,
  input logic              rst,
  stage_sequencer_if.slave bus
);

  localparam int MAX_CNT = (TRANS_CYCLES > OVER_HOLD) ? TRANS_CYCLES : OVER_HOLD;
  localparam int CW      = ($clog2(MAX_CNT + 1) > 8) ? $clog2(MAX_CNT + 1) : 8;

  localparam logic [CW-1:0] TRANS_LAST = CW'(TRANS_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(OVER_HOLD - 1);
  localparam logic [3:0]    LAST_LEVEL = 4'(NUM_LEVELS);

  typedef enum logic [2:0] {
    ST_TITLE = 3'd0,
    ST_INTRO = 3'd1,
    ST_PLAY  = 3'd2,
    ST_CLEAR = 3'd3,
    ST_OVER  = 3'd4,
    ST_WIN   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          enter_q;
  logic [3:0]    stage_q, stage_d;
  logic [4:0]    mc_q, mc_d;
  logic          freeze_q, freeze_d;
  logic          lstart_q, lstart_d;

  logic          enter_rise_s;
  logic [4:0]    keys_s;
  logic [CW-1:0] cnt_term_s;

  assign enter_rise_s = bus.key_enter & ~enter_q;
  assign keys_s       = {bus.key_space, bus.key_s, bus.key_w, bus.key_d, bus.key_a};

  // Next-state and level sequencing.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    case (state_q)
      ST_TITLE: begin
        if (enter_rise_s) begin
          state_d = ST_INTRO;
          level_d = 4'd1;
        end else begin
          state_d = ST_TITLE;
        end
      end
      ST_INTRO: begin
        if (cnt_q == TRANS_LAST) begin
          state_d = ST_PLAY;
        end else begin
          state_d = ST_INTRO;
        end
      end
      ST_PLAY: begin
        if (bus.lives == 4'd0) begin
          state_d = ST_OVER;
        end else if (bus.level_clear && (level_q == LAST_LEVEL)) begin
          state_d = ST_WIN;
        end else if (bus.level_clear) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == TRANS_LAST) begin
          state_d = ST_INTRO;
          level_d = level_q + 4'd1;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_OVER, ST_WIN: begin
        if ((cnt_q == HOLD_LAST) && enter_rise_s) begin
          state_d = ST_TITLE;
          level_d = 4'd1;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_TITLE;
        level_d = 4'd1;
      end
    endcase
  end

  // Freeze counter: restarts on every state change, saturates at the state's terminal count.
  always_comb begin
    cnt_term_s = TRANS_LAST;
    cnt_d      = cnt_q;
    if ((state_q == ST_OVER) || (state_q == ST_WIN)) begin
      cnt_term_s = HOLD_LAST;
    end else begin
      cnt_term_s = TRANS_LAST;
    end
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q != ST_TITLE) && (state_q != ST_PLAY) && (cnt_q != cnt_term_s)) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Outputs are decoded from the next state so stage, freeze and key masking switch on the same edge.
  always_comb begin
    stage_d  = 4'd0;
    freeze_d = 1'b1;
    mc_d     = 5'd0;
    lstart_d = 1'b0;
    case (state_d)
      ST_TITLE: stage_d = 4'h0;
      ST_INTRO: stage_d = level_d;
      ST_PLAY: begin
        stage_d  = level_d;
        freeze_d = 1'b0;
        mc_d     = keys_s;
        lstart_d = (state_q != ST_PLAY);
      end
      ST_CLEAR: stage_d = level_d;
      ST_OVER:  stage_d = 4'hf;
      ST_WIN:   stage_d = 4'he;
      default:  stage_d = 4'h0;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_TITLE;
      level_q  <= 4'd1;
      cnt_q    <= '0;
      enter_q  <= 1'b0;
      stage_q  <= 4'd0;
      mc_q     <= 5'd0;
      freeze_q <= 1'b1;
      lstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      enter_q  <= bus.key_enter;
      stage_q  <= stage_d;
      mc_q     <= mc_d;
      freeze_q <= freeze_d;
      lstart_q <= lstart_d;
    end
  end

  assign bus.stage       = stage_q;
  assign bus.mc_a        = mc_q[0];
  assign bus.mc_d        = mc_q[1];
  assign bus.mc_w        = mc_q[2];
  assign bus.mc_s        = mc_q[3];
  assign bus.mc_space    = mc_q[4];
  assign bus.freeze      = freeze_q;
  assign bus.level_start = lstart_q;
  assign bus.fsm_state   = state_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: a cycle model pushes expected outputs per driven cycle,
// and these are popped and compared once the DUT has clocked.
module tb_stage_sequencer;

  localparam int NL = 3;
  localparam int TC = 6;
  localparam int OH = 16;

  typedef struct packed {
    logic [3:0] stage;
    logic       freeze;
    logic [4:0] mc;
    logic       ls;
    logic [2:0] fsm;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stage_sequencer_if bus();

  stage_sequencer #(.NUM_LEVELS(NL), .TRANS_CYCLES(TC), .OVER_HOLD(OH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  int m_state = 0;
  int m_level = 1;
  int m_cnt   = 0;
  bit m_enter = 1'b0;

  int ls_seen    = 0;
  int intro_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: model the cycle, push the expectation, clock the DUT, pop and compare.
  task automatic step();
    exp_t       e;
    exp_t       got;
    int         ns;
    int         nl;
    int         last;
    bit         rise;
    logic [4:0] keys;
    keys = {bus.key_space, bus.key_s, bus.key_w, bus.key_d, bus.key_a};
    if (rst) begin
      ns = 0; nl = 1; m_cnt = 0; m_enter = 1'b0;
      e.ls = 1'b0;
    end else begin
      rise = bus.key_enter && !m_enter;
      ns = m_state; nl = m_level;
      if (m_state == 0 && rise) begin ns = 1; nl = 1; end
      if (m_state == 1 && m_cnt == TC - 1) ns = 2;
      if (m_state == 2) begin
        if (bus.lives == 4'd0) ns = 4;
        else if (bus.level_clear && m_level == NL) ns = 5;
        else if (bus.level_clear) ns = 3;
      end
      if (m_state == 3 && m_cnt == TC - 1) begin ns = 1; nl = m_level + 1; end
      if ((m_state == 4 || m_state == 5) && m_cnt == OH - 1 && rise) begin ns = 0; nl = 1; end
      last = (m_state >= 4) ? OH - 1 : TC - 1;
      if (ns != m_state) m_cnt = 0;
      else if (m_state != 0 && m_state != 2 && m_cnt < last) m_cnt++;
      e.ls = (ns == 2) && (m_state != 2);
      m_enter = bus.key_enter;
    end
    e.fsm    = 3'(ns);
    e.stage  = (ns == 0) ? 4'h0 : (ns == 4) ? 4'hf : (ns == 5) ? 4'he : 4'(nl);
    e.freeze = (ns != 2);
    e.mc     = (ns == 2) ? keys : 5'd0;
    m_state  = ns;
    m_level  = nl;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    got.stage  = bus.stage;
    got.freeze = bus.freeze;
    got.mc     = {bus.mc_space, bus.mc_s, bus.mc_w, bus.mc_d, bus.mc_a};
    got.ls     = bus.level_start;
    got.fsm    = bus.fsm_state;
    check_eq("stage", 32'(got.stage), 32'(e.stage));
    check_eq("freeze", 32'(got.freeze), 32'(e.freeze));
    check_eq("mc_keys", 32'(got.mc), 32'(e.mc));
    check_eq("level_start", 32'(got.ls), 32'(e.ls));
    check_eq("fsm_state", 32'(got.fsm), 32'(e.fsm));
    if (bus.level_start === 1'b1) ls_seen++;
    if (bus.fsm_state === 3'd1) intro_seen++;
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget);
    int n;
    n = 0;
    while (bus.fsm_state !== target && n < budget) begin
      step();
      n++;
    end
    check_eq("reach_state", 32'(bus.fsm_state), 32'(target));
  endtask

  task automatic enter_pulse();
    bus.key_enter = 1'b1;
    step();
    bus.key_enter = 1'b0;
    step();
  endtask

  task automatic clear_pulse();
    bus.level_clear = 1'b1;
    step();
    bus.level_clear = 1'b0;
  endtask

  task automatic random_keys(input int n);
    for (int i = 0; i < n; i++) begin
      {bus.key_space, bus.key_s, bus.key_w, bus.key_d, bus.key_a} = 5'($urandom_range(0, 31));
      step();
    end
    {bus.key_space, bus.key_s, bus.key_w, bus.key_d, bus.key_a} = 5'd0;
  endtask

  initial begin
    rst = 1'b1;
    {bus.key_space, bus.key_s, bus.key_w, bus.key_d, bus.key_a} = 5'd0;
    bus.key_enter   = 1'b0;
    bus.lives       = 4'd3;
    bus.level_clear = 1'b0;
    step();
    step();
    rst = 1'b0;
    ls_seen    = 0;
    intro_seen = 0;

    // Held ENTER must start exactly one game.
    bus.key_enter = 1'b1;
    repeat (5) step();
    bus.key_enter = 1'b0;
    wait_state(3'd2, 50);
    check_eq("intro_len", 32'(intro_seen), 32'(TC));
    check_eq("ls_once", 32'(ls_seen), 32'd1);

    // Key passthrough, then masking on the CLEAR edge.
    bus.key_w = 1'b1;
    repeat (3) step();
    check_eq("mc_w_play", 32'(bus.mc_w), 32'd1);
    clear_pulse();
    check_eq("mc_w_frozen", 32'(bus.mc_w), 32'd0);
    check_eq("clear_stage", 32'(bus.stage), 32'd1);
    wait_state(3'd1, 50);
    check_eq("intro2_stage", 32'(bus.stage), 32'd2);
    bus.key_w = 1'b0;

    // Levels 2 and 3, then victory and the ENTER hold.
    wait_state(3'd2, 50);
    random_keys(8);
    clear_pulse();
    wait_state(3'd2, 50);
    random_keys(4);
    clear_pulse();
    check_eq("win_stage", 32'(bus.stage), 32'he);
    repeat (9) step();
    enter_pulse();
    check_eq("win_hold", 32'(bus.fsm_state), 32'd5);
    repeat (OH) step();
    enter_pulse();
    check_eq("win_exit", 32'(bus.stage), 32'd0);

    // lives==0 beats level_clear in the same cycle.
    enter_pulse();
    wait_state(3'd2, 50);
    bus.lives       = 4'd0;
    bus.level_clear = 1'b1;
    step();
    bus.lives       = 4'd3;
    bus.level_clear = 1'b0;
    check_eq("over_state", 32'(bus.fsm_state), 32'd4);
    check_eq("over_stage", 32'(bus.stage), 32'hf);
    repeat (3) step();
    enter_pulse();
    check_eq("over_hold", 32'(bus.fsm_state), 32'd4);
    repeat (OH) step();
    enter_pulse();
    check_eq("over_exit", 32'(bus.fsm_state), 32'd0);
    enter_pulse();
    check_eq("restart_stage", 32'(bus.stage), 32'd1);

    // Reset during CLEAR at level 2 with keys held.
    wait_state(3'd2, 50);
    clear_pulse();
    wait_state(3'd2, 50);
    clear_pulse();
    step();
    check_eq("clear2_stage", 32'(bus.stage), 32'd2);
    {bus.key_space, bus.key_s, bus.key_w, bus.key_d, bus.key_a} = 5'h1f;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rst_fsm", 32'(bus.fsm_state), 32'd0);
    check_eq("rst_freeze", 32'(bus.freeze), 32'd1);
    check_eq("rst_mc", 32'({bus.mc_space, bus.mc_s, bus.mc_w, bus.mc_d, bus.mc_a}), 32'd0);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
